// File: rtl/keypad_scan_decoder_4x4_pkg.sv
// Shared types and constants for the 4x4 keypad scan decoder.
// Imported by the decoder top, its handshake interface and the bench.
package keypad_pkg;

    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 4;
    localparam int KEY_W    = 4;

    typedef enum logic [1:0] {IDLE, CONFIRM, HELD} state_t;
    typedef enum logic [1:0] {NONE, SINGLE, MULTI} scan_t;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'b0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/keypad_scan_decoder_4x4_if.sv
// Key report handshake between the keypad decoder and its consumer.
// The decoder drives the master modport; the consumer uses slave.
interface keypad_scan_decoder_4x4_if;
    import keypad_pkg::*;

    logic             key_valid;
    logic             key_ready;
    logic [KEY_W-1:0] key_code;
    logic             key_down;

    modport master (output key_valid, output key_code, output key_down, input key_ready);
    modport slave  (input key_valid, input key_code, input key_down, output key_ready);
endinterface

// File: rtl/keypad_scan_decoder_4x4_onehot_enc4.sv
// 4-bit one-hot to 2-bit index encoder; valid is low for zero or multi-hot input.
// Reused for column-strobe decode and per-column row decode.
module onehot_enc4 (
    input  logic [3:0] onehot,
    output logic [1:0] idx,
    output logic       valid
);
    always_comb begin
        idx   = 2'd0;
        valid = 1'b0;
        case (onehot)
            4'b0001: begin idx = 2'd0; valid = 1'b1; end
            4'b0010: begin idx = 2'd1; valid = 1'b1; end
            4'b0100: begin idx = 2'd2; valid = 1'b1; end
            4'b1000: begin idx = 2'd3; valid = 1'b1; end
            default: begin idx = 2'd0; valid = 1'b0; end
        endcase
    end
endmodule

// File: rtl/keypad_scan_decoder_4x4.sv
// 4x4 keypad scan decoder: builds a snapshot per full column scan, debounces
// presses and releases across scans, and reports single key presses.
module keypad_scan_decoder_4x4
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 3,
    parameter int CNT_W          = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_COLS-1:0]               col_sel,
    input  logic [NUM_ROWS-1:0]               rows,
    input  logic                              overrun_clr,
    output logic                              col_err,
    output logic                              overrun,
    keypad_scan_decoder_4x4_if.master         key
);
    localparam logic [CNT_W-1:0] DEB = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [1:0]       col_idx;
    logic             col_vld;
    logic [1:0]       exp_col_reg;
    logic [15:0]      snapshot_reg;
    logic             col_err_reg;
    logic             col0_sample, legal, scan_done;
    logic [15:0]      snap_full;
    logic [1:0]       row_idx [NUM_COLS];
    logic [NUM_COLS-1:0] row_vld;
    logic [KEY_W-1:0] scan_key;
    scan_t            scan_res;

    onehot_enc4 u_col_enc (.onehot(col_sel), .idx(col_idx), .valid(col_vld));

    // A lone column-0 strobe always restarts a scan, even out of sequence.
    assign col0_sample = (col_sel == 4'b0001);
    assign legal       = col0_sample || (col_vld && (col_idx == exp_col_reg));
    assign scan_done   = legal && (col_idx == 2'd3);
    assign snap_full   = {rows, snapshot_reg[11:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snapshot_reg <= '0;
            exp_col_reg  <= 2'd0;
            col_err_reg  <= 1'b0;
        end else begin
            col_err_reg <= !legal;
            if (col0_sample) begin
                snapshot_reg <= {12'b0, rows};
                exp_col_reg  <= 2'd1;
            end else if (legal) begin
                snapshot_reg[4*col_idx +: 4] <= rows;
                exp_col_reg                  <= col_idx + 2'd1;
            end else begin
                snapshot_reg <= '0;
                exp_col_reg  <= 2'd0;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_row_enc
        onehot_enc4 u_row_enc (
            .onehot(snap_full[4*gi +: 4]),
            .idx   (row_idx[gi]),
            .valid (row_vld[gi])
        );
    end

    // Key position is only meaningful when exactly one snapshot bit is set.
    always_comb begin
        scan_key = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            if (row_vld[i]) scan_key = {2'(i), row_idx[i]};
        end
        case (popcount16(snap_full))
            5'd0:    scan_res = NONE;
            5'd1:    scan_res = SINGLE;
            default: scan_res = MULTI;
        endcase
    end

    state_t           state_reg, state_next;
    logic [KEY_W-1:0] cand_reg, cand_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next, rcnt_reg, rcnt_next;
    logic             report;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cand_reg  <= '0;
            cnt_reg   <= '0;
            rcnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cand_reg  <= cand_next;
            cnt_reg   <= cnt_next;
            rcnt_reg  <= rcnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cand_next  = cand_reg;
        cnt_next   = cnt_reg;
        rcnt_next  = rcnt_reg;
        report     = 1'b0;
        if (scan_done) begin
            case (state_reg)
                IDLE: begin
                    if (scan_res == SINGLE) begin
                        cand_next = scan_key;
                        cnt_next  = ONE;
                        if (DEB == ONE) begin
                            state_next = HELD;
                            rcnt_next  = '0;
                            report     = 1'b1;
                        end else begin
                            state_next = CONFIRM;
                        end
                    end
                end
                CONFIRM: begin
                    if (scan_res == SINGLE && scan_key == cand_reg) begin
                        if (cnt_reg >= DEB - ONE) begin
                            cnt_next   = DEB;
                            rcnt_next  = '0;
                            state_next = HELD;
                            report     = 1'b1;
                        end else begin
                            cnt_next = cnt_reg + ONE;
                        end
                    end else if (scan_res == SINGLE) begin
                        cand_next = scan_key;
                        cnt_next  = ONE;
                    end else begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                end
                HELD: begin
                    if (scan_res == NONE) begin
                        if (rcnt_reg >= DEB - ONE) begin
                            state_next = IDLE;
                            rcnt_next  = '0;
                            cnt_next   = '0;
                        end else begin
                            rcnt_next = rcnt_reg + ONE;
                        end
                    end else begin
                        rcnt_next = '0;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    logic             key_valid_reg, overrun_reg, accept;
    logic [KEY_W-1:0] key_code_reg;

    assign accept = key_valid_reg && key.key_ready;

    // A report collides with a pending code unless that code leaves this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_valid_reg <= 1'b0;
            key_code_reg  <= '0;
            overrun_reg   <= 1'b0;
        end else begin
            if (report && (!key_valid_reg || accept)) begin
                key_valid_reg <= 1'b1;
                key_code_reg  <= cand_next;
            end else if (accept) begin
                key_valid_reg <= 1'b0;
            end
            if (overrun_clr) overrun_reg <= 1'b0;
            else if (report && key_valid_reg && !accept) overrun_reg <= 1'b1;
        end
    end

    assign key.key_valid = key_valid_reg;
    assign key.key_code  = key_code_reg;
    assign key.key_down  = (state_reg == HELD);
    assign col_err       = col_err_reg;
    assign overrun       = overrun_reg;

endmodule

// File: tb/tb_keypad_scan_decoder_4x4.sv
// Scenario bench for the keypad scan decoder against a scan-history model.
module tb_keypad_scan_decoder_4x4;
    import keypad_pkg::*;

    localparam int D = 3;
    localparam logic [15:0] K6 = 16'h0040, K3 = 16'h0008, K9 = 16'h0200, K5 = 16'h0020;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic [3:0] col_sel = 4'b0, rows = 4'b0;
    logic       overrun_clr = 1'b0;
    logic       col_err, overrun;
    int         checks = 0, passed = 0;

    keypad_scan_decoder_4x4_if kif ();

    keypad_scan_decoder_4x4 #(.DEBOUNCE_SCANS(D), .CNT_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .col_sel(col_sel), .rows(rows),
        .overrun_clr(overrun_clr), .col_err(col_err), .overrun(overrun), .key(kif)
    );

    always #5 clk = ~clk;

    // Model: history of classified scans (-1 none, -2 multi, else key index).
    logic [15:0] m_snap;
    int          m_expcol, idle_start, hold_start;
    int          hist[$];
    bit          m_err, m_held, m_valid, m_ov;
    logic [3:0]  m_code;

    task automatic model_reset();
        m_snap = '0; m_expcol = 0; idle_start = 0; hold_start = 0;
        hist.delete(); m_err = 0; m_held = 0; m_valid = 0; m_ov = 0; m_code = '0;
    endtask

    task automatic model_scan(input logic [15:0] s, output bit rep, output int k);
        int c, n;
        bit ok;
        rep = 0; k = 0;
        n = $countones(s);
        c = (n == 0) ? -1 : (n > 1) ? -2 : 0;
        if (n == 1) for (int i = 0; i < 16; i++) if (s[i]) c = i;
        hist.push_back(c);
        n = hist.size();
        if (!m_held && n - idle_start >= D && c >= 0) begin
            ok = 1;
            for (int i = 1; i <= D; i++) if (hist[n-i] != c) ok = 0;
            if (ok) begin rep = 1; k = c; m_held = 1; hold_start = n; end
        end else if (m_held && n - hold_start >= D) begin
            ok = 1;
            for (int i = 1; i <= D; i++) if (hist[n-i] != -1) ok = 0;
            if (ok) begin m_held = 0; idle_start = n; end
        end
    endtask

    task automatic cycle(input logic [3:0] c, input logic [3:0] r);
        bit acc, rep, ov_set;
        int k, idx;
        @(negedge clk);
        col_sel = c; rows = r;
        @(posedge clk);
        acc = m_valid && kif.key_ready; rep = 0; ov_set = 0; k = 0; idx = 0;
        for (int i = 0; i < 4; i++) if (c[i]) idx = i;
        m_err = 0;
        if (c == 4'b0001) begin
            m_snap = {12'b0, r}; m_expcol = 1;
        end else if ($countones(c) == 1 && idx == m_expcol) begin
            m_snap[4*idx +: 4] = r;
            m_expcol = (idx + 1) % 4;
            if (idx == 3) model_scan(m_snap, rep, k);
        end else begin
            m_err = 1; m_snap = '0; m_expcol = 0;
        end
        if (rep) begin
            if (!m_valid || acc) begin m_valid = 1; m_code = 4'(k); end
            else ov_set = 1;
            $display("report key=%0d loaded=%0d t=%0t", k, !ov_set, $time);
        end else if (acc) m_valid = 0;
        if (overrun_clr) m_ov = 0;
        else if (ov_set) m_ov = 1;
        #1;
    endtask

    task automatic scan(input logic [15:0] s);
        for (int c = 0; c < 4; c++) cycle(4'(1 << c), s[4*c +: 4]);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; kif.key_ready = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        checks++; if (kif.key_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", kif.key_valid); else passed++;
        checks++; if (kif.key_code !== 4'd0) $display("FAIL reset_code got %0d want 0", kif.key_code); else passed++;
        checks++; if (kif.key_down !== 1'b0) $display("FAIL reset_down got %b want 0", kif.key_down); else passed++;
        checks++; if (col_err !== 1'b0) $display("FAIL reset_colerr got %b want 0", col_err); else passed++;
        checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", overrun); else passed++;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_press_release();
        kif.key_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            scan(K6);
            checks++; if (kif.key_valid !== 1'b0) $display("FAIL press_early_valid scan %0d got %b want 0", i, kif.key_valid); else passed++;
        end
        scan(K6);
        checks++; if (kif.key_valid !== 1'b1) $display("FAIL press_valid got %b want 1", kif.key_valid); else passed++;
        checks++; if (kif.key_code !== 4'd6) $display("FAIL press_code got %0d want 6", kif.key_code); else passed++;
        checks++; if (kif.key_down !== 1'b1) $display("FAIL press_down got %b want 1", kif.key_down); else passed++;
        cycle(4'b0001, 4'b0);
        checks++; if (kif.key_valid !== 1'b0) $display("FAIL press_valid_drop got %b want 0", kif.key_valid); else passed++;
        cycle(4'b0010, 4'b0); cycle(4'b0100, 4'b0); cycle(4'b1000, 4'b0);
        scan(16'h0);
        checks++; if (kif.key_down !== 1'b1) $display("FAIL release_early_down got %b want 1", kif.key_down); else passed++;
        scan(16'h0);
        checks++; if (kif.key_down !== 1'b0) $display("FAIL release_down got %b want 0", kif.key_down); else passed++;
    endtask

    task automatic test_interrupted();
        logic [15:0] seq [6] = '{K6, K6, 16'h0, K6, K6, K6};
        int seen = 0;
        for (int i = 0; i < 6; i++) begin
            scan(seq[i]);
            if (kif.key_valid === 1'b1) seen++;
        end
        checks++; if (seen !== 1) $display("FAIL interrupt_reports got %0d want 1", seen); else passed++;
        checks++; if (kif.key_valid !== 1'b1 || kif.key_code !== 4'd6) $display("FAIL interrupt_last got v=%b c=%0d want v=1 c=6", kif.key_valid, kif.key_code); else passed++;
        repeat (3) scan(16'h0);
    endtask

    task automatic test_multi();
        int bad = 0;
        for (int i = 0; i < 5; i++) begin
            scan(16'h8001);
            if (kif.key_valid !== 1'b0 || kif.key_down !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) $display("FAIL multi_no_report got %0d bad scans want 0", bad); else passed++;
    endtask

    task automatic test_col_fault();
        scan(K6); scan(K6);
        cycle(4'b0001, 4'b0);
        cycle(4'b0010, 4'b0100);
        cycle(4'b1000, 4'b0);
        checks++; if (col_err !== 1'b1) $display("FAIL colfault_pulse got %b want 1", col_err); else passed++;
        checks++; if (kif.key_valid !== 1'b0) $display("FAIL colfault_noscan got %b want 0", kif.key_valid); else passed++;
        cycle(4'b0001, 4'b0);
        checks++; if (col_err !== 1'b0) $display("FAIL colfault_once got %b want 0", col_err); else passed++;
        cycle(4'b0010, 4'b0100); cycle(4'b0100, 4'b0); cycle(4'b1000, 4'b0);
        checks++; if (kif.key_valid !== 1'b1 || kif.key_code !== 4'd6) $display("FAIL colfault_resume got v=%b c=%0d want v=1 c=6", kif.key_valid, kif.key_code); else passed++;
        repeat (3) scan(16'h0);
    endtask

    task automatic test_overrun();
        kif.key_ready = 1'b0;
        repeat (3) scan(K3);
        repeat (3) scan(16'h0);
        repeat (3) scan(K9);
        checks++; if (kif.key_code !== 4'd3 || kif.key_valid !== 1'b1) $display("FAIL overrun_keep got v=%b c=%0d want v=1 c=3", kif.key_valid, kif.key_code); else passed++;
        checks++; if (overrun !== 1'b1) $display("FAIL overrun_set got %b want 1", overrun); else passed++;
        kif.key_ready = 1'b1;
        cycle(4'b0001, 4'b0);
        cycle(4'b0010, 4'b0);
        checks++; if (kif.key_valid !== 1'b0 || overrun !== 1'b1) $display("FAIL overrun_accept got v=%b ov=%b want v=0 ov=1", kif.key_valid, overrun); else passed++;
        overrun_clr = 1'b1;
        cycle(4'b0100, 4'b0);
        overrun_clr = 1'b0;
        checks++; if (overrun !== 1'b0) $display("FAIL overrun_clr got %b want 0", overrun); else passed++;
        cycle(4'b1000, 4'b0);
        repeat (2) scan(16'h0);
    endtask

    task automatic test_mid_reset();
        kif.key_ready = 1'b0;
        repeat (3) scan(K6);
        repeat (3) scan(16'h0);
        scan(K5); scan(K5);
        cycle(4'b0001, 4'b0); cycle(4'b0010, 4'b0010);
        @(negedge clk);
        col_sel = 4'b0100; rows = 4'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (kif.key_valid !== 1'b0 || kif.key_code !== 4'd0) $display("FAIL midrst_key got v=%b c=%0d want 0 0", kif.key_valid, kif.key_code); else passed++;
        checks++; if (kif.key_down !== 1'b0 || col_err !== 1'b0 || overrun !== 1'b0) $display("FAIL midrst_flags got d=%b e=%b o=%b want 0", kif.key_down, col_err, overrun); else passed++;
        model_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;
        cycle(4'b1000, 4'b0);
        checks++; if (col_err !== 1'b1) $display("FAIL midrst_fault got %b want 1", col_err); else passed++;
        scan(K5); scan(K5);
        checks++; if (kif.key_valid !== 1'b0) $display("FAIL midrst_early got %b want 0", kif.key_valid); else passed++;
        scan(K5);
        checks++; if (kif.key_valid !== 1'b1 || kif.key_code !== 4'd5) $display("FAIL midrst_report got v=%b c=%0d want v=1 c=5", kif.key_valid, kif.key_code); else passed++;
        kif.key_ready = 1'b1;
        repeat (3) scan(16'h0);
    endtask

    task automatic test_random();
        logic [15:0] pat = '0;
        int r;
        for (int n = 0; n < 160; n++) begin
            kif.key_ready = ($urandom_range(0, 3) != 0);
            overrun_clr   = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 9) == 0) begin
                cycle(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
                checks++; if (col_err !== m_err) $display("FAIL rand_colerr n=%0d got %b want %b", n, col_err, m_err); else passed++;
            end
            r = $urandom_range(0, 9);
            if (r >= 5 && r < 7) pat = '0;
            else if (r >= 7 && r < 9) pat = 16'(1 << $urandom_range(0, 15));
            else if (r == 9) pat = 16'($urandom);
            scan(pat);
            checks++; if (kif.key_valid !== m_valid) $display("FAIL rand_valid n=%0d got %b want %b", n, kif.key_valid, m_valid); else passed++;
            checks++; if (kif.key_code !== m_code) $display("FAIL rand_code n=%0d got %0d want %0d", n, kif.key_code, m_code); else passed++;
            checks++; if (kif.key_down !== m_held) $display("FAIL rand_down n=%0d got %b want %b", n, kif.key_down, m_held); else passed++;
            checks++; if (overrun !== m_ov) $display("FAIL rand_overrun n=%0d got %b want %b", n, overrun, m_ov); else passed++;
            checks++; if (col_err !== m_err) $display("FAIL rand_colok n=%0d got %b want %b", n, col_err, m_err); else passed++;
        end
        overrun_clr = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_press_release();
        test_interrupted();
        test_multi();
        test_col_fault();
        test_overrun();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/keypad_scan_decoder_4x4.md
Name: keypad_scan_decoder_4x4

Overview:
- Downstream consumer of the 4-bit one-hot ring counter. The counter's one-hot output drives the columns of a 4x4 key matrix; this block samples the matrix rows against that column strobe.
- It assembles one 16-bit snapshot per full scan, debounces across scans and reports single key presses as a 4-bit code over a valid/ready handshake.
- It also flags column-sequence faults and handshake overruns.

Parameters:
- DEBOUNCE_SCANS, 3, consecutive identical full scans required to accept a press and to accept a release (range 1..15).
- CNT_W, 4, width of the debounce counters (must hold DEBOUNCE_SCANS).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- col_sel  input  4  one-hot column strobe from the ring counter; bit i high = column i driven this cycle.
- rows  input  4  row sense lines for the driven column, active-high, same-cycle valid.
- key_ready  input  1  consumer accepts key_code when high together with key_valid.
- key_valid  output  1  a debounced press is pending.
- key_code  output  4  pending key index = 4*col + row.
- key_down  output  1  a debounced key is currently held.
- col_err  output  1  one-cycle pulse on a column-sequence fault.
- overrun  output  1  sticky; a new press was dropped because key_valid was still pending.
- overrun_clr  input  1  clears overrun (has priority over a same-cycle set).

Behaviour:
- Reset, async on rst_n low: key_valid=0, key_code=0, key_down=0, col_err=0, overrun=0, FSM=IDLE, snapshot=0, expected column=0, both counters=0.
- Column tracking: each cycle, col_sel is decoded to an index.
  - Legal sample: col_sel is one-hot and its index equals the expected column. Write rows into snapshot[4*idx +: 4]; expected column = idx+1 mod 4.
  - Fault: col_sel not one-hot, or index differs from the expected column. col_err pulses next cycle; snapshot is cleared; expected column resets to 0.
  - Fault with col_sel==0001: the cycle is treated as a fresh column-0 sample, not an error.
- Scan complete: the cycle a legal column-3 sample is written. Evaluate the scan:
  - NONE: no snapshot bits set.
  - SINGLE(k): exactly one bit k set.
  - MULTI: two or more bits set.
- Snapshot is cleared when the next column-0 sample is written.
- FSM, advances only on scan-complete cycles:
  - IDLE: on SINGLE(k), cand=k and cnt=1. Go to HELD (and report) if DEBOUNCE_SCANS==1, else CONFIRM. On NONE or MULTI, stay.
  - CONFIRM: on SINGLE(cand), cnt+1; when cnt reaches DEBOUNCE_SCANS, report and go to HELD. On SINGLE(j≠cand), cand=j and cnt=1. On NONE or MULTI, go to IDLE, cnt=0.
  - HELD: key_down=1. On NONE, rcnt+1; when rcnt reaches DEBOUNCE_SCANS, go to IDLE, key_down=0. On SINGLE(cand), rcnt=0. On MULTI or SINGLE(j≠cand), rcnt=0; no new report until release.
- Report:
  - key_valid=1 and key_code=cand on the cycle after the confirming scan-complete. Latency is 1 clk from the final column-3 sample.
  - key_down rises the same cycle.
- Handshake:
  - key_valid and key_code are held stable until key_valid & key_ready; key_valid drops the next cycle.
  - A report while key_valid=1 (not accepted that cycle) is dropped, sets overrun and leaves key_code unchanged.
  - A report in the same cycle as an acceptance loads the new code and keeps key_valid=1.
- Mid-scan reset: all state returns to reset values immediately; the first legal scan starts at the next column-0 sample.
- Counter widths: cnt and rcnt saturate at DEBOUNCE_SCANS; there is no wrap.

Decomposition:
- Package keypad_pkg:
  - FSM state enum: IDLE, CONFIRM, HELD.
  - Scan-result enum: NONE, SINGLE, MULTI.
  - Constants NUM_COLS=4, NUM_ROWS=4, KEY_W=4.
- Sub-module onehot_enc4: 4-bit one-hot to 2-bit index plus a valid flag. It is reused for column decode and row decode.
- The single-bit and popcount check for the 16-bit snapshot stays local to the block.

Test Plan:
- Press key 6 (col 1, row 2, rows=0100 during col_sel=0010) for 3 full scans, key_ready=1 → key_valid pulses 1 cycle after the 3rd column-3 sample with key_code=6, key_down=1. Release for 3 scans → key_down=0.
- Key 6 for 2 scans, then NONE, then 3 scans → exactly one report, after the last 3 scans, key_code=6.
- Keys 0 and 15 held together (MULTI) for 5 scans → no key_valid; FSM stays IDLE.
- col_sel sequence 0001, 0010, 1000 → col_err pulses once; no scan completes until the following 0001, 0010, 0100, 1000.
- key_ready=0; press key 3, release, press key 9 (each debounced) → key_code stays 3 and overrun=1. key_ready=1 → accepted. overrun_clr → overrun=0.
- rst_n low during column 2 of a confirming scan → all outputs 0 asynchronously; after release, 3 fresh scans are needed to report.
